blink_sched: RTL and testbench

BLINK_SCHED -- requirements
Module: blink_sched

---
 rtl/blink_sched.sv | 127 ++++++++++++
 tb/tb_blink_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sched.sv
// rtl/blink_sched.sv - round-robin scheduler granting a shared LED for fixed-length blink bursts
module blink_sched #(
  parameter int CBITS  = 4,
  parameter int BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       led,
  output logic [3:0] grant,
  output logic [1:0] gid,
  output logic       busy,
  output logic       done,
  output logic       tick
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam logic [3:0] LAST = 4'(BLINKS - 1);

  state_t           state, state_n;
  logic [CBITS-1:0] pre;
  logic [3:0]       bcnt, bcnt_n;
  logic [1:0]       ptr, ptr_n, gid_n;
  logic [1:0]       win, idx;
  logic             win_ok;
  logic             led_n, busy_n, done_n;
  logic [3:0]       grant_n;

  assign tick = (pre == {CBITS{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= pre + 1'b1;
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!win_ok && req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    ptr_n   = ptr;
    gid_n   = gid;
    led_n   = led;
    grant_n = grant;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tick && en && win_ok) begin
          state_n = ON;
          grant_n = 4'b0001 << win;
          gid_n   = win;
          ptr_n   = win;
          bcnt_n  = '0;
          led_n   = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          state_n = OFF;
          led_n   = 1'b0;
        end
      end
      OFF: begin
        if (tick) begin
          if (bcnt == LAST) begin
            state_n = GAP;
            grant_n = '0;
            done_n  = 1'b1;
          end else begin
            bcnt_n  = bcnt + 1'b1;
            state_n = ON;
            led_n   = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Disable aborts any burst immediately, without a completion pulse.
    if (!en && state != IDLE) begin
      state_n = IDLE;
      led_n   = 1'b0;
      grant_n = '0;
      done_n  = 1'b0;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bcnt  <= '0;
      ptr   <= 2'd3;
      gid   <= '0;
      led   <= 1'b0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      ptr   <= ptr_n;
      gid   <= gid_n;
      led   <= led_n;
      grant <= grant_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_blink_sched.sv
// tb/tb_blink_sched.sv - self-checking bench for blink_sched with a timeline-based reference model
module tb_blink_sched;
  localparam int CB = 2;
  localparam int B  = 3;
  localparam int P  = 4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic       led, busy, done, tick;
  logic [3:0] grant;
  logic [1:0] gid;

  blink_sched #(.CBITS(CB), .BLINKS(B)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .led(led), .grant(grant), .gid(gid), .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a burst is an interval of edges starting at bstart; everything follows from elapsed time.
  int   n, bstart, owner, mptr, mgid;
  bit   active;
  logic prev_done;
  logic e_led, e_busy, e_done, e_tick;
  logic [3:0] e_grant;
  logic [1:0] e_gid;

  typedef struct {
    int         edge_n;
    logic [3:0] grant;
    logic       led, done, busy, tick;
    logic [1:0] gid;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    n = 0; active = 0; bstart = 0; owner = 0; mptr = 3; mgid = 0;
  endfunction

  function automatic void model_edge(input logic men, input logic [3:0] mreq);
    bit found;
    n++;
    if (active && !men) active = 0;
    else if (active) begin
      if (n - bstart >= (2 * B + 1) * P) active = 0;
    end else if ((n % P) == 0 && men && mreq != 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (mptr + k) % 4;
        if (!found && mreq[c]) begin
          owner = c;
          found = 1;
        end
      end
      mptr = owner; mgid = owner; bstart = n; active = 1;
    end
  endfunction

  function automatic void model_outputs();
    int e;
    e_grant = '0; e_led = 0; e_done = 0; e_busy = 0;
    if (active) begin
      e = n - bstart;
      e_busy = 1;
      if (e < 2 * B * P) begin
        e_grant = 4'(1 << owner);
        e_led   = ((e / P) % 2) == 0;
      end
      e_done = (e == 2 * B * P);
    end
    e_gid  = 2'(mgid);
    e_tick = (n % P) == (P - 1);
  endfunction

  task automatic check_all();
    chk("led",   8'(led),   8'(e_led));
    chk("grant", 8'(grant), 8'(e_grant));
    chk("gid",   8'(gid),   8'(e_gid));
    chk("busy",  8'(busy),  8'(e_busy));
    chk("done",  8'(done),  8'(e_done));
    chk("tick",  8'(tick),  8'(e_tick));
    chk("inv_onehot",  8'($onehot0(grant)), 8'd1);
    chk("inv_busy",    8'((grant != 0) && !busy), 8'd0);
    chk("inv_led",     8'(led && grant == 0), 8'd0);
    chk("inv_done2",   8'(done && prev_done), 8'd0);
    prev_done = done;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(en, req);
    #1;
    model_outputs();
    check_all();
  endtask

  // Assert reset between edges, confirm the asynchronous clear, release on the falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    model_outputs();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int   grants_seen, done_cnt, led_rises, gstart;
  logic prev_led;
  logic [3:0] prev_grant;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[1] = '{4,  4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{8,  4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[3] = '{12, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[4] = '{27, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[5] = '{28, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[6] = '{29, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[7] = '{32, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[8] = '{35, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[9] = '{36, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};

    rst = 1'b1; en = 1'b1; req = 4'b0010; prev_done = 1'b0;

    // Single requester held: fixed timeline from reset release.
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      for (int i = 0; i < 10; i++) begin
        if (tbl[i].edge_n == e) begin
          chk("tbl_grant", 8'(grant), 8'(tbl[i].grant));
          chk("tbl_led",   8'(led),   8'(tbl[i].led));
          chk("tbl_done",  8'(done),  8'(tbl[i].done));
          chk("tbl_busy",  8'(busy),  8'(tbl[i].busy));
          chk("tbl_tick",  8'(tick),  8'(tbl[i].tick));
          chk("tbl_gid",   8'(gid),   8'(tbl[i].gid));
        end
      end
    end

    // All four requesting: round-robin order and burst length.
    req = 4'b1111;
    do_reset();
    grants_seen = 0; done_cnt = 0; prev_grant = '0; gstart = 0;
    for (int e = 1; e <= 200 && grants_seen < 5; e++) begin
      step();
      if (done) done_cnt++;
      if (grant != 0 && prev_grant == 0) begin
        chk("rr_order", 8'(gid), 8'(grants_seen % 4));
        grants_seen++;
        gstart = e;
      end
      if (grant == 0 && prev_grant != 0) chk("burst_len", 8'(e - gstart), 8'(2 * B * P));
      prev_grant = grant;
    end
    chk("rr_grants", 8'(grants_seen), 8'd5);
    chk("rr_dones",  8'(done_cnt),    8'd4);

    // One-cycle request just before the arbitration tick still yields a full burst.
    req = 4'b0000;
    do_reset();
    for (int e = 1; e <= 3; e++) step();
    req = 4'b0001;
    step();
    req = 4'b0000;
    led_rises = 0; done_cnt = 0; prev_led = 1'b0;
    if (led) led_rises++;
    prev_led = led;
    for (int e = 5; e <= 44; e++) begin
      step();
      if (led && !prev_led) led_rises++;
      if (done) done_cnt++;
      prev_led = led;
    end
    chk("pulse_rises", 8'(led_rises), 8'd3);
    chk("pulse_done",  8'(done_cnt),  8'd1);
    chk("pulse_idle",  8'(grant),     8'd0);

    // Enable dropped in the second ON phase, then restored.
    req = 4'b0001;
    do_reset();
    for (int e = 1; e <= 13; e++) step();
    en = 1'b0;
    step();
    chk("abort_led",   8'(led),   8'd0);
    chk("abort_grant", 8'(grant), 8'd0);
    chk("abort_busy",  8'(busy),  8'd0);
    chk("abort_done",  8'(done),  8'd0);
    for (int e = 15; e <= 18; e++) step();
    en = 1'b1; req = 4'b0011;
    step();
    step();
    chk("resume_gid",   8'(gid),   8'd1);
    chk("resume_grant", 8'(grant), 8'b0010);

    // Reset in the middle of an OFF phase, then normal timing again.
    req = 4'b0010;
    do_reset();
    for (int e = 1; e <= 9; e++) step();
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e == 3) chk("rst_tick3",  8'(tick),  8'd1);
    end
    chk("rst_regrant", 8'(grant), 8'b0010);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
